// File: rtl/y_seq_ctrl.sv
// y_seq_ctrl: multi-cycle sequencer for the yIF/yID/yEX datapath.
// Latches the fetched instruction and walks FETCH..WB per opcode. It drives the
// datapath selects, the memory strobes and the PC update, and stops after run_len
// instructions or on HALT.
// Optional feature macro: RETIRE_CNT_EN. When it is defined, the 'retired' port
// exposes the run counter.
module y_seq_ctrl #(
  parameter int unsigned CNT_W      = 16,
  parameter logic [5:0]  HALT_FUNCT = 6'h0C
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] run_len,
  input  logic [31:0]      ins,
  input  logic             zero,
  output logic             busy,
  output logic             done,
  output logic [2:0]       state,
  output logic             pc_en,
  output logic [1:0]       pc_sel,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrc,
  output logic [2:0]       op,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             Mem2Reg
`ifdef RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0] retired
`endif
);

  localparam logic [2:0] st_idle   = 3'd0;
  localparam logic [2:0] st_fetch  = 3'd1;
  localparam logic [2:0] st_decode = 3'd2;
  localparam logic [2:0] st_exec   = 3'd3;
  localparam logic [2:0] st_mem    = 3'd4;
  localparam logic [2:0] st_wb     = 3'd5;
  localparam logic [2:0] st_done   = 3'd6;

  logic [2:0]       state_q, state_d;
  logic [31:0]      ir_q, ir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, len_q, len_d;

  logic [5:0] opcode, funct;
  logic       r_valid, is_r, is_halt, is_addi, is_lw, is_sw, is_beq, is_j;
  logic [2:0] r_op, alu_op;
  logic [2:0] last_st;
  logic       retire, in_ex;

  // Only opcode and funct steer control; the register fields go to the datapath.
  logic ir_unused;
  assign ir_unused = ^ir_q[25:6];

  assign opcode = ir_q[31:26];
  assign funct  = ir_q[5:0];

  // Instruction class decode from the latched IR
  always_comb begin
    r_valid = 1'b1;
    r_op    = 3'b000;
    case (funct)
      6'h20:   r_op = 3'b010;
      6'h22:   r_op = 3'b110;
      6'h24:   r_op = 3'b000;
      6'h25:   r_op = 3'b001;
      6'h2A:   r_op = 3'b111;
      default: r_valid = 1'b0;
    endcase
    is_halt = (opcode == 6'h00) && (funct == HALT_FUNCT);
    is_r    = (opcode == 6'h00) && r_valid && !is_halt;
    is_addi = (opcode == 6'h08);
    is_lw   = (opcode == 6'h23);
    is_sw   = (opcode == 6'h2B);
    is_beq  = (opcode == 6'h04);
    is_j    = (opcode == 6'h02);
    // Anything not matched above (unknown opcode/funct) falls through as a NOP
    if (is_r)                        alu_op = r_op;
    else if (is_addi | is_lw | is_sw) alu_op = 3'b010;
    else if (is_beq)                 alu_op = 3'b110;
    else                             alu_op = 3'b000;
    if (is_r | is_addi | is_lw) last_st = st_wb;
    else if (is_sw)             last_st = st_mem;
    else if (is_beq)            last_st = st_exec;
    else                        last_st = st_decode;
  end

  // Last state of a non-HALT instruction: PC update and retirement happen here
  assign retire = (state_q == last_st) && !is_halt;
  assign in_ex  = (state_q >= st_decode) && (state_q <= st_wb);

  // Next-state, IR capture and run counter
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    case (state_q)
      st_idle, st_done: begin
        if (start) begin
          state_d = st_fetch;
          cnt_d   = '0;
          len_d   = run_len;
        end
      end
      st_fetch: begin
        ir_d    = ins;
        state_d = st_decode;
      end
      st_decode: state_d = is_halt ? st_done : st_exec;
      st_exec:   state_d = (is_lw | is_sw) ? st_mem : st_wb;
      st_mem:    state_d = st_wb;
      st_wb:     state_d = st_wb;
      default:   state_d = st_idle;
    endcase
    if (retire) begin
      // Counter wraps freely; a zero run length never matches, so the run is unbounded
      cnt_d   = cnt_q + CNT_W'(1);
      state_d = ((len_q != '0) && (cnt_d == len_q)) ? st_done : st_fetch;
    end
  end

  // State registers, asynchronous active-high reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= st_idle;
      ir_q    <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  // Control outputs, decoded from IR and state; selects held DECODE..last state
  always_comb begin
    state    = state_q;
    busy     = (state_q >= st_fetch) && (state_q <= st_wb);
    done     = (state_q == st_done);
    RegDst   = in_ex && is_r;
    ALUSrc   = in_ex && (is_addi | is_lw | is_sw);
    op       = in_ex ? alu_op : 3'b000;
    RegWrite = (state_q == st_wb) && (is_r | is_addi | is_lw);
    Mem2Reg  = (state_q == st_wb) && is_lw;
    MemRead  = (state_q == st_mem) && is_lw;
    MemWrite = (state_q == st_mem) && is_sw;
    pc_en    = retire;
    pc_sel   = 2'd0;
    if (retire) begin
      if (is_j)                pc_sel = 2'd2;
      else if (is_beq && zero) pc_sel = 2'd1;
    end
  end

`ifdef RETIRE_CNT_EN
  assign retired = cnt_q;
`endif

endmodule
